hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/flopr.sv | 22 ++
 rtl/fwd_sel.sv | 38 +++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared pipeline encodings: forward selects and multicycle FSM states.
// Revision: 1.0
// ============================================================================
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register 15 is the PC and is never a forwarding target.
  localparam int PC_ADDR = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_if
// Brief   : Pipeline-to-hazard-unit bundle; master is the pipeline datapath.
// Revision: 1.0
// ============================================================================
interface hazard_ctrl_if #(
  parameter int RA_W = 4
);
  logic [RA_W-1:0] ra1_d, ra2_d;
  logic [RA_W-1:0] ra1_e, ra2_e;
  logic [RA_W-1:0] wa3_e, wa3_m, wa3_w;
  logic            regwrite_m, regwrite_w;
  logic            memtoreg_e;
  logic            branch_taken_e;
  logic            mc_start_e;
  logic [1:0]      fwd_ae, fwd_be;
  logic            stall_f, stall_d, stall_e;
  logic            flush_d, flush_e, flush_m;
  logic            mc_busy, mc_done;

  modport master (
    output ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w,
           regwrite_m, regwrite_w, memtoreg_e, branch_taken_e, mc_start_e,
    input  fwd_ae, fwd_be, stall_f, stall_d, stall_e,
           flush_d, flush_e, flush_m, mc_busy, mc_done
  );

  modport slave (
    input  ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w,
           regwrite_m, regwrite_w, memtoreg_e, branch_taken_e, mc_start_e,
    output fwd_ae, fwd_be, stall_f, stall_d, stall_e,
           flush_d, flush_e, flush_m, mc_busy, mc_done
  );
endinterface
`default_nettype wire

// File: rtl/flopr.sv
`default_nettype none
// ============================================================================
// Module  : flopr
// Brief   : Resettable D flop bank, asynchronous active-high reset to zero.
// Revision: 1.0
// ============================================================================
module flopr #(
  parameter int W = 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic [W-1:0] i_d,
  output logic      [W-1:0] o_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_q <= '0;
    else       o_q <= i_d;
  end

endmodule
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module  : fwd_sel
// Brief   : ALU operand forward select for one Execute source register.
// Revision: 1.0
// ============================================================================
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int RA_W = 4
) (
  input  wire logic [RA_W-1:0] i_ra_e,
  input  wire logic [RA_W-1:0] i_wa3_m,
  input  wire logic [RA_W-1:0] i_wa3_w,
  input  wire logic            i_regwrite_m,
  input  wire logic            i_regwrite_w,
  output logic      [1:0]      o_fwd
);

  logic w_is_pc;
  logic w_hit_m;
  logic w_hit_w;

  assign w_is_pc = (i_ra_e == RA_W'(PC_ADDR));
  assign w_hit_m = i_regwrite_m && (i_wa3_m == i_ra_e);
  assign w_hit_w = i_regwrite_w && (i_wa3_w == i_ra_e);

  // The younger (Memory) result wins over Writeback.
  always_comb begin
    o_fwd = FWD_RF;
    if (!w_is_pc) begin
      if (w_hit_m)      o_fwd = FWD_MEM;
      else if (w_hit_w) o_fwd = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Forwarding, load-use stall, branch flush and multicycle-op hold.
// Revision: 1.0
// ============================================================================
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W   = 4,
  parameter int MC_LAT = 4
) (
  input  wire logic    clk,
  input  wire logic    reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 2);

  logic [0:0]       r_state_bits;
  mc_state_t        r_state;
  mc_state_t        w_state_nxt;
  logic [0:0]       w_state_nxt_bits;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_mc_hold;
  logic             w_mc_done;
  logic             w_ldstall;

  fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .i_ra_e       (bus.ra1_e),
    .i_wa3_m      (bus.wa3_m),
    .i_wa3_w      (bus.wa3_w),
    .i_regwrite_m (bus.regwrite_m),
    .i_regwrite_w (bus.regwrite_w),
    .o_fwd        (bus.fwd_ae)
  );

  fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .i_ra_e       (bus.ra2_e),
    .i_wa3_m      (bus.wa3_m),
    .i_wa3_w      (bus.wa3_w),
    .i_regwrite_m (bus.regwrite_m),
    .i_regwrite_w (bus.regwrite_w),
    .o_fwd        (bus.fwd_be)
  );

  assign w_state_nxt_bits = w_state_nxt;
  assign r_state          = mc_state_t'(r_state_bits);

  flopr #(.W(1)) u_state_ff (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_state_nxt_bits),
    .o_q   (r_state_bits)
  );

  flopr #(.W(CNT_W)) u_cnt_ff (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_cnt_nxt),
    .o_q   (r_cnt)
  );

  // cnt counts the remaining held BUSY cycles; the release cycle is cnt==0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_hold   = 1'b0;
    w_mc_done   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (bus.mc_start_e) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_INIT;
          w_mc_hold   = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_mc_hold = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_mc_done   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_ldstall = bus.memtoreg_e &&
                     ((bus.wa3_e == bus.ra1_d) || (bus.wa3_e == bus.ra2_d));

  always_comb begin
    bus.stall_f = 1'b0;
    bus.stall_d = 1'b0;
    bus.stall_e = 1'b0;
    bus.flush_d = 1'b0;
    bus.flush_e = 1'b0;
    bus.flush_m = 1'b0;
    if (w_mc_hold) begin
      bus.stall_f = 1'b1;
      bus.stall_d = 1'b1;
      bus.stall_e = 1'b1;
      bus.flush_m = 1'b1;
    end else if (bus.branch_taken_e) begin
      bus.flush_d = 1'b1;
      bus.flush_e = 1'b1;
    end else if (w_ldstall) begin
      bus.stall_f = 1'b1;
      bus.stall_d = 1'b1;
      bus.flush_e = 1'b1;
    end
  end

  assign bus.mc_busy = (r_state == BUSY);
  assign bus.mc_done = w_mc_done;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Scoreboard bench for hazard_ctrl (MC_LAT=4 and MC_LAT=2 instances).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_ctrl;
  import pipe_pkg::*;

  typedef struct packed {
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       sf, sd, se, fd, fe, fm, busy, done;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.RA_W(4)) bus  ();
  hazard_ctrl_if #(.RA_W(4)) bus2 ();

  hazard_ctrl #(.RA_W(4), .MC_LAT(4)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  hazard_ctrl #(.RA_W(4), .MC_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  int    n_tests = 0;
  int    n_fail  = 0;
  out_t  sb[$];
  string sb_name[$];

  function automatic out_t mk(input logic [1:0] fae, input logic [1:0] fbe,
                              input logic sf, input logic sd, input logic se,
                              input logic fd, input logic fe, input logic fm,
                              input logic busy, input logic done);
    out_t o;
    o = '{fae, fbe, sf, sd, se, fd, fe, fm, busy, done};
    return o;
  endfunction

  function automatic out_t obs1();
    return mk(bus.fwd_ae, bus.fwd_be, bus.stall_f, bus.stall_d, bus.stall_e,
              bus.flush_d, bus.flush_e, bus.flush_m, bus.mc_busy, bus.mc_done);
  endfunction

  function automatic out_t obs2();
    return mk(bus2.fwd_ae, bus2.fwd_be, bus2.stall_f, bus2.stall_d, bus2.stall_e,
              bus2.flush_d, bus2.flush_e, bus2.flush_m, bus2.mc_busy, bus2.mc_done);
  endfunction

  function automatic logic [1:0] fwd_model(input logic rwm, input logic [3:0] wam,
                                           input logic rww, input logic [3:0] waw,
                                           input logic [3:0] ra);
    if (ra == 4'd15)         return 2'b00;
    if (rwm && (wam == ra))  return 2'b10;
    if (rww && (waw == ra))  return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    bus.ra1_d = '0; bus.ra2_d = '0; bus.ra1_e = '0; bus.ra2_e = '0;
    bus.wa3_e = '0; bus.wa3_m = '0; bus.wa3_w = '0;
    bus.regwrite_m = 0; bus.regwrite_w = 0; bus.memtoreg_e = 0;
    bus.branch_taken_e = 0; bus.mc_start_e = 0;
    bus2.ra1_d = '0; bus2.ra2_d = '0; bus2.ra1_e = '0; bus2.ra2_e = '0;
    bus2.wa3_e = '0; bus2.wa3_m = '0; bus2.wa3_w = '0;
    bus2.regwrite_m = 0; bus2.regwrite_w = 0; bus2.memtoreg_e = 0;
    bus2.branch_taken_e = 0; bus2.mc_start_e = 0;
  endtask

  task automatic test_reset();
    out_t exp, got;
    string nm;
    reset = 1'b1;
    clear_inputs();
    #3;
    sb.push_back('0); sb_name.push_back("reset_dut");
    sb.push_back('0); sb_name.push_back("reset_dut2");
    @(negedge clk);
    exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs1();
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
    exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs2();
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
    reset = 1'b0;
  endtask

  task automatic test_forwarding();
    logic [3:0] t_wam[6] = '{4'd3, 4'd3, 4'd15, 4'd7, 4'd5, 4'd9};
    logic [3:0] t_waw[6] = '{4'd3, 4'd3, 4'd15, 4'd2, 4'd5, 4'd9};
    logic       t_rwm[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       t_rww[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] t_ra1[6] = '{4'd3, 4'd3, 4'd15, 4'd2, 4'd5, 4'd9};
    logic [3:0] t_ra2[6] = '{4'd4, 4'd3, 4'd15, 4'd7, 4'd5, 4'd9};
    out_t exp, got;
    string nm;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i < 6) begin
        bus.regwrite_m = t_rwm[i]; bus.wa3_m = t_wam[i];
        bus.regwrite_w = t_rww[i]; bus.wa3_w = t_waw[i];
        bus.ra1_e = t_ra1[i];      bus.ra2_e = t_ra2[i];
      end else begin
        bus.regwrite_m = 1'($urandom_range(1)); bus.wa3_m = 4'($urandom_range(15));
        bus.regwrite_w = 1'($urandom_range(1)); bus.wa3_w = 4'($urandom_range(15));
        bus.ra1_e = bus.wa3_m;                  bus.ra2_e = 4'($urandom_range(15));
      end
      sb.push_back(mk(fwd_model(bus.regwrite_m, bus.wa3_m, bus.regwrite_w, bus.wa3_w, bus.ra1_e),
                      fwd_model(bus.regwrite_m, bus.wa3_m, bus.regwrite_w, bus.wa3_w, bus.ra2_e),
                      0, 0, 0, 0, 0, 0, 0, 0));
      sb_name.push_back($sformatf("fwd_vec%0d", i));
      @(negedge clk);
      exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs1();
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
    end
    clear_inputs();
  endtask

  task automatic test_ldstall();
    logic [3:0] t_ra1[4] = '{4'd0, 4'd0, 4'd5, 4'd5};
    logic [3:0] t_ra2[4] = '{4'd5, 4'd6, 4'd6, 4'd5};
    logic       t_mem[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       t_stl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    out_t exp, got;
    string nm;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.memtoreg_e = t_mem[i]; bus.wa3_e = 4'd5;
      bus.ra1_d = t_ra1[i];      bus.ra2_d = t_ra2[i];
      sb.push_back(mk(0, 0, t_stl[i], t_stl[i], 0, 0, t_stl[i], 0, 0, 0));
      sb_name.push_back($sformatf("ldstall_vec%0d", i));
      @(negedge clk);
      exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs1();
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
    end
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    out_t exp, got;
    string nm;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.branch_taken_e = 1'b1;
      bus.memtoreg_e = (i == 0); bus.wa3_e = 4'd5; bus.ra2_d = 4'd5;
      sb.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      sb_name.push_back($sformatf("branch_vec%0d", i));
      @(negedge clk);
      exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs1();
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
    end
    clear_inputs();
  endtask

  task automatic test_multicycle();
    out_t plan[5];
    out_t exp, got;
    string nm;
    plan[0] = mk(0, 0, 1, 1, 1, 0, 0, 1, 0, 0);
    plan[1] = mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 0);
    plan[2] = mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 0);
    plan[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    plan[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus.mc_start_e     = (c < 4);
      bus.branch_taken_e = (c == 2);
      sb.push_back(plan[c]);
      sb_name.push_back($sformatf("mc_cycle%0d", c + 1));
      @(negedge clk);
      exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs1();
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_op();
    out_t exp, got;
    string nm;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      bus.mc_start_e = 1'b1;
      sb.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, (c == 1), 0));
      sb_name.push_back($sformatf("rst_mid_cycle%0d", c + 1));
      @(negedge clk);
      exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs1();
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
    end
    #2;
    reset = 1'b1;
    clear_inputs();
    sb.push_back('0); sb_name.push_back("rst_async_outputs");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs1();
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    sb.push_back('0); sb_name.push_back("rst_after_release");
    @(negedge clk);
    exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs1();
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic test_back_to_back();
    out_t exp, got;
    string nm;
    logic hold;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus2.mc_start_e = (c < 4);
      hold = (c == 0) || (c == 2);
      sb.push_back(mk(0, 0, hold, hold, hold, 0, 0, hold,
                      (c == 1) || (c == 3), (c == 1) || (c == 3)));
      sb_name.push_back($sformatf("b2b_cycle%0d", c + 1));
      @(negedge clk);
      exp = sb.pop_front(); nm = sb_name.pop_front(); got = obs2();
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_ldstall();
    test_branch_priority();
    test_multicycle();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
